physical_regfile_sb: RTL and testbench
======================================

// Module: physical_regfile_sb
// PURPOSE
//  Parametrised physical register file with an integrated per-register ready scoreboard.
//  Sits between rename/dispatch (allocates PRs, queries operand readiness) and the
//  issue/execute stage (reads operands, completes via CDB write-back).
//  Generalises width, depth and port counts. Adds ready bits, write-collision detection,
//  branch-recovery restore of ready state, and an optional registered read stage.
// PARAMETERS
//  XLEN      32  data width per register
//  PR_W      6   PR index width; depth = 2**PR_W
//  N_WR      3   CDB write-back ports
//  N_RD      3   read channels, each with an A and a B operand
//  N_ALLOC   3   rename allocation ports; 2*N_ALLOC readiness-query ports
//  ZERO_PR   0   hard-wired zero register index
//  READ_REG  0   0 = combinational read with bypass; 1 = read registered, 1-cycle latency
// PORTS
//  clock          in   1                 rising-edge clock
//  reset          in   1                 asynchronous, active-low
//  wr_en          in   N_WR              write-back valid, per port
//  wr_idx         in   N_WR*PR_W         write-back PR index
//  wr_data        in   N_WR*XLEN         write-back data
//  rd_valid       in   N_RD              read request valid (pipelined when READ_REG=1)
//  rda_idx        in   N_RD*PR_W         operand A index
//  rdb_idx        in   N_RD*PR_W         operand B index
//  rda_out        out  N_RD*XLEN         operand A data
//  rdb_out        out  N_RD*XLEN         operand B data
//  rd_out_valid   out  N_RD              data valid (= rd_valid if READ_REG=0)
//  alloc_en       in   N_ALLOC           PR newly allocated by rename -> mark not-ready
//  alloc_idx      in   N_ALLOC*PR_W      allocated PR index
//  chk_idx        in   2*N_ALLOC*PR_W    source PRs queried by rename
//  chk_rdy        out  2*N_ALLOC         readiness of each queried PR
//  recover_en     in   1                 branch recovery: load ready table from mask
//  recover_mask   in   2**PR_W           ready-bit image to restore
//  wr_collision   out  1                 sticky: two enabled write ports hit the same PR
// BEHAVIOUR
//  Reset (async, reset==0): all data = 0; all ready bits = 1; rda/rdb_out = 0;
//   rd_out_valid = 0; wr_collision = 0. Takes effect immediately, including mid-operation.
//  Write: next[wr_idx[i]] = wr_data[i] for each enabled i, with wr_idx[i] != ZERO_PR.
//   Same-index writes: the highest port number wins; wr_collision sets and holds until reset.
//  ZERO_PR: always reads 0, always ready; writes, allocs and recovery to it are ignored.
//  Read, READ_REG=0: out = next-state data (same-cycle write bypass), zero-cycle latency.
//  Read, READ_REG=1: out <= next-state data at the edge. rd_out_valid <= rd_valid.
//   Data visible one cycle after the request. Outputs hold when rd_valid=0.
//  Ready table, update priority per PR at the clock edge:
//   recover_en > alloc > write.
//   - recover_en: rdy <= recover_mask (ZERO_PR forced 1). Data writes still occur.
//   - alloc_en[j]: rdy[alloc_idx[j]] <= 0. Wins over a same-cycle write to that PR.
//   - wr_en[i]: rdy[wr_idx[i]] <= 1.
//  chk_rdy[k] is combinational: rdy[chk_idx[k]] OR (any enabled write to chk_idx[k]
//   this cycle). Same-cycle alloc and recover are NOT visible.
//  Ready bits do not gate reads. Issue logic guarantees that operands are ready.
// STRUCTURE
//  Shared package (sys_defs):
//   - PR index typedef
//   - CDB packet struct (per-port valid/idx)
//   - ZERO_PR and XLEN defines
//  Sub-module pr_ready_table: ready bits, priority update, chk_rdy bypass.
//  Top: data array, write mux/collision detect, read muxes, optional read register.
// TESTING
//  1. Reset: read any PR -> 0; chk on any PR -> 1; wr_collision = 0.
//  2. wr port0 PR5=0xDEAD, read PR5 same cycle, READ_REG=0 -> rda_out=0xDEAD.
//     READ_REG=1 -> 0xDEAD and rd_out_valid one cycle later.
//  3. ports 0 and 2 both write PR9 (0x11, 0x22) -> PR9=0x22 next cycle; wr_collision=1, sticky.
//  4. alloc PR7 -> chk PR7=0 next cycle; CDB write PR7 -> chk_rdy=1 in the same cycle
//     (bypass); reg bit=1 after the edge.
//  5. alloc and write PR12 same cycle -> PR12 not ready.
//     recover_en with mask bit12=1 -> PR12 ready; ZERO_PR stays ready with mask bit0=0.
//  6. write ZERO_PR=0xFFFF -> reads 0. Assert reset mid-burst -> outputs 0 immediately.

Source files
------------

// File: rtl/physical_regfile_sb_pkg.sv
// Shared definitions for the physical register file and its ready scoreboard.
package physical_regfile_sb_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned PR_W_DEF    = 6;
  localparam int unsigned ZERO_PR_DEF = 0;

  typedef logic [PR_W_DEF-1:0] pr_idx_t;

  typedef struct packed {
    logic    valid;
    pr_idx_t idx;
  } cdb_t;

endpackage

// File: rtl/physical_regfile_sb_pr_ready_table.sv
// Per-PR ready bits: recover > alloc > write priority, with write bypass on queries.
module physical_regfile_sb_pr_ready_table
  import physical_regfile_sb_pkg::*;
#(
  parameter int unsigned PR_W    = PR_W_DEF,
  parameter int unsigned N_WR    = 3,
  parameter int unsigned N_ALLOC = 3,
  parameter int unsigned ZERO_PR = ZERO_PR_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WR-1:0]             wr_en,
  input  logic [N_WR*PR_W-1:0]        wr_idx,
  input  logic [N_ALLOC-1:0]          alloc_en,
  input  logic [N_ALLOC*PR_W-1:0]     alloc_idx,
  input  logic [2*N_ALLOC*PR_W-1:0]   chk_idx,
  input  logic                        recover_en,
  input  logic [(2**PR_W)-1:0]        recover_mask,
  output logic [2*N_ALLOC-1:0]        chk_rdy
);

  localparam int unsigned DEPTH = 2**PR_W;
  localparam int unsigned N_CHK = 2*N_ALLOC;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] rdy_nxt;
  logic [PR_W-1:0]  cidx;

  always_comb begin
    rdy_nxt = rdy;
    if (recover_en) begin
      rdy_nxt = recover_mask;
    end else begin
      // Allocation loop runs after writes so alloc wins on a shared PR.
      for (int unsigned i = 0; i < N_WR; i++)
        if (wr_en[i]) rdy_nxt[wr_idx[i*PR_W +: PR_W]] = 1'b1;
      for (int unsigned j = 0; j < N_ALLOC; j++)
        if (alloc_en[j]) rdy_nxt[alloc_idx[j*PR_W +: PR_W]] = 1'b0;
    end
    rdy_nxt[ZERO_PR] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdy <= '1;
    else        rdy <= rdy_nxt;
  end

  always_comb begin
    chk_rdy = '0;
    cidx    = '0;
    for (int unsigned k = 0; k < N_CHK; k++) begin
      cidx       = chk_idx[k*PR_W +: PR_W];
      chk_rdy[k] = rdy[cidx] | (cidx == PR_W'(ZERO_PR));
      for (int unsigned i = 0; i < N_WR; i++)
        if (wr_en[i] && (wr_idx[i*PR_W +: PR_W] == cidx)) chk_rdy[k] = 1'b1;
    end
  end

endmodule

// File: rtl/physical_regfile_sb.sv
// Physical register file with write bypass, collision flag, optional read register and ready scoreboard.
module physical_regfile_sb
  import physical_regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned PR_W     = PR_W_DEF,
  parameter int unsigned N_WR     = 3,
  parameter int unsigned N_RD     = 3,
  parameter int unsigned N_ALLOC  = 3,
  parameter int unsigned ZERO_PR  = ZERO_PR_DEF,
  parameter int unsigned READ_REG = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WR-1:0]             wr_en,
  input  logic [N_WR*PR_W-1:0]        wr_idx,
  input  logic [N_WR*XLEN-1:0]        wr_data,
  input  logic [N_RD-1:0]             rd_valid,
  input  logic [N_RD*PR_W-1:0]        rda_idx,
  input  logic [N_RD*PR_W-1:0]        rdb_idx,
  output logic [N_RD*XLEN-1:0]        rda_out,
  output logic [N_RD*XLEN-1:0]        rdb_out,
  output logic [N_RD-1:0]             rd_out_valid,
  input  logic [N_ALLOC-1:0]          alloc_en,
  input  logic [N_ALLOC*PR_W-1:0]     alloc_idx,
  input  logic [2*N_ALLOC*PR_W-1:0]   chk_idx,
  output logic [2*N_ALLOC-1:0]        chk_rdy,
  input  logic                        recover_en,
  input  logic [(2**PR_W)-1:0]        recover_mask,
  output logic                        wr_collision
);

  localparam int unsigned DEPTH = 2**PR_W;

  logic [XLEN-1:0]      regs     [DEPTH];
  logic [XLEN-1:0]      regs_nxt [DEPTH];
  logic                 collide;
  logic [N_RD*XLEN-1:0] rda_comb;
  logic [N_RD*XLEN-1:0] rdb_comb;

  // Ascending port order makes the highest enabled port win a shared index.
  always_comb begin
    regs_nxt = regs;
    for (int unsigned i = 0; i < N_WR; i++)
      if (wr_en[i] && (wr_idx[i*PR_W +: PR_W] != PR_W'(ZERO_PR)))
        regs_nxt[wr_idx[i*PR_W +: PR_W]] = wr_data[i*XLEN +: XLEN];
  end

  always_comb begin
    collide = 1'b0;
    for (int unsigned i = 0; i < N_WR; i++)
      for (int unsigned j = i + 1; j < N_WR; j++)
        if (wr_en[i] && wr_en[j] && (wr_idx[i*PR_W +: PR_W] == wr_idx[j*PR_W +: PR_W]))
          collide = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
      wr_collision <= 1'b0;
    end else begin
      regs         <= regs_nxt;
      wr_collision <= wr_collision | collide;
    end
  end

  always_comb begin
    rda_comb = '0;
    rdb_comb = '0;
    for (int unsigned c = 0; c < N_RD; c++) begin
      rda_comb[c*XLEN +: XLEN] = regs_nxt[rda_idx[c*PR_W +: PR_W]];
      rdb_comb[c*XLEN +: XLEN] = regs_nxt[rdb_idx[c*PR_W +: PR_W]];
    end
  end

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [N_RD*XLEN-1:0] rda_q;
      logic [N_RD*XLEN-1:0] rdb_q;
      logic [N_RD-1:0]      vld_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          rda_q <= '0;
          rdb_q <= '0;
          vld_q <= '0;
        end else begin
          vld_q <= rd_valid;
          for (int unsigned c = 0; c < N_RD; c++)
            if (rd_valid[c]) begin
              rda_q[c*XLEN +: XLEN] <= rda_comb[c*XLEN +: XLEN];
              rdb_q[c*XLEN +: XLEN] <= rdb_comb[c*XLEN +: XLEN];
            end
        end
      end

      assign rda_out      = rda_q;
      assign rdb_out      = rdb_q;
      assign rd_out_valid = vld_q;
    end else begin : g_read_comb
      // The bypass path is combinational, so reset must also gate it directly.
      assign rda_out      = reset ? rda_comb : '0;
      assign rdb_out      = reset ? rdb_comb : '0;
      assign rd_out_valid = reset ? rd_valid : '0;
    end
  endgenerate

  physical_regfile_sb_pr_ready_table #(
    .PR_W    (PR_W),
    .N_WR    (N_WR),
    .N_ALLOC (N_ALLOC),
    .ZERO_PR (ZERO_PR)
  ) u_ready_table (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .alloc_en     (alloc_en),
    .alloc_idx    (alloc_idx),
    .chk_idx      (chk_idx),
    .recover_en   (recover_en),
    .recover_mask (recover_mask),
    .chk_rdy      (chk_rdy)
  );

endmodule

// File: tb/tb_physical_regfile_sb.sv
// Directed scoreboard bench for physical_regfile_sb with combinational reads.
module tb_physical_regfile_sb;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PR_W    = 6;
  localparam int unsigned N_WR    = 3;
  localparam int unsigned N_RD    = 3;
  localparam int unsigned N_ALLOC = 3;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned N_CHK   = 6;

  localparam int unsigned K_RDA  = 0;
  localparam int unsigned K_RDB  = 1;
  localparam int unsigned K_CHK  = 2;
  localparam int unsigned K_COL  = 3;
  localparam int unsigned K_VLD  = 4;
  localparam int unsigned K_RAWA = 5;
  localparam int unsigned K_RAWB = 6;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [N_WR-1:0]          wr_en;
  logic [N_WR*PR_W-1:0]     wr_idx;
  logic [N_WR*XLEN-1:0]     wr_data;
  logic [N_RD-1:0]          rd_valid;
  logic [N_RD*PR_W-1:0]     rda_idx;
  logic [N_RD*PR_W-1:0]     rdb_idx;
  logic [N_RD*XLEN-1:0]     rda_out;
  logic [N_RD*XLEN-1:0]     rdb_out;
  logic [N_RD-1:0]          rd_out_valid;
  logic [N_ALLOC-1:0]       alloc_en;
  logic [N_ALLOC*PR_W-1:0]  alloc_idx;
  logic [N_CHK*PR_W-1:0]    chk_idx;
  logic [N_CHK-1:0]         chk_rdy;
  logic                     recover_en;
  logic [DEPTH-1:0]         recover_mask;
  logic                     wr_collision;

  physical_regfile_sb #(
    .XLEN     (XLEN),
    .PR_W     (PR_W),
    .N_WR     (N_WR),
    .N_RD     (N_RD),
    .N_ALLOC  (N_ALLOC),
    .ZERO_PR  (0),
    .READ_REG (0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rda_idx      (rda_idx),
    .rdb_idx      (rdb_idx),
    .rda_out      (rda_out),
    .rdb_out      (rdb_out),
    .rd_out_valid (rd_out_valid),
    .alloc_en     (alloc_en),
    .alloc_idx    (alloc_idx),
    .chk_idx      (chk_idx),
    .chk_rdy      (chk_rdy),
    .recover_en   (recover_en),
    .recover_mask (recover_mask),
    .wr_collision (wr_collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int unsigned cyc;
    int unsigned kind;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc     = 0;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic expect_item(input string name, input int unsigned kind,
                             input int unsigned sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.cyc = cyc; e.kind = kind; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    logic        ok;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e   = sbq.pop_front();
        act = '0;
        ok  = 1'b1;
        case (e.kind)
          K_RDA:  begin act = rda_out[e.sel*XLEN +: XLEN]; ok = rd_out_valid[e.sel]; end
          K_RDB:  begin act = rdb_out[e.sel*XLEN +: XLEN]; ok = rd_out_valid[e.sel]; end
          K_CHK:  act = {31'b0, chk_rdy[e.sel]};
          K_COL:  act = {31'b0, wr_collision};
          K_VLD:  act = {29'b0, rd_out_valid};
          K_RAWA: act = rda_out[e.sel*XLEN +: XLEN];
          default: act = rdb_out[e.sel*XLEN +: XLEN];
        endcase
        ok = ok && (e.cyc == cyc) && (act === e.exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h valid=%b required=%h", e.name, cyc, act, rd_out_valid, e.exp);
      end
    end
  end

  task automatic idle();
    wr_en = '0; wr_idx = '0; wr_data = '0;
    rd_valid = '0; rda_idx = '0; rdb_idx = '0;
    alloc_en = '0; alloc_idx = '0; chk_idx = '0;
    recover_en = 1'b0; recover_mask = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic wr(input int unsigned p, input logic [PR_W-1:0] idx, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_idx[p*PR_W +: PR_W] = idx;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int unsigned c, input logic [PR_W-1:0] a, input logic [PR_W-1:0] b);
    rd_valid[c] = 1'b1;
    rda_idx[c*PR_W +: PR_W] = a;
    rdb_idx[c*PR_W +: PR_W] = b;
  endtask

  task automatic alloc(input int unsigned j, input logic [PR_W-1:0] idx);
    alloc_en[j] = 1'b1;
    alloc_idx[j*PR_W +: PR_W] = idx;
  endtask

  task automatic chk(input int unsigned k, input logic [PR_W-1:0] idx);
    chk_idx[k*PR_W +: PR_W] = idx;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b0;
    idle();

    step();
    rd(0, 5, 63); chk(0, 5); chk(1, 63);
    expect_item("rst_rda0", K_RAWA, 0, 32'h0);
    expect_item("rst_vld",  K_VLD,  0, 32'h0);
    expect_item("rst_chk5", K_CHK,  0, 32'h1);
    expect_item("rst_chk63", K_CHK, 1, 32'h1);
    expect_item("rst_col",  K_COL,  0, 32'h0);

    step(); reset = 1'b1;
    rd(0, 5, 63); rd(1, 0, 9);
    chk(0, 5); chk(1, 7); chk(2, 9); chk(3, 12); chk(4, 0); chk(5, 63);
    expect_item("init_rda0", K_RDA, 0, 32'h0);
    expect_item("init_rdb0", K_RDB, 0, 32'h0);
    expect_item("init_rda1", K_RDA, 1, 32'h0);
    expect_item("init_rdb1", K_RDB, 1, 32'h0);
    for (int unsigned k = 0; k < N_CHK; k++) expect_item("init_chk", K_CHK, k, 32'h1);
    expect_item("init_col", K_COL, 0, 32'h0);
    expect_item("init_vld", K_VLD, 0, 32'h3);

    step(); wr(0, 5, 32'hDEAD); rd(0, 5, 0);
    expect_item("bypass_pr5", K_RDA, 0, 32'hDEAD);
    expect_item("bypass_pr0", K_RDB, 0, 32'h0);

    step(); rd(2, 9, 5);
    expect_item("stored_pr5", K_RDB, 2, 32'hDEAD);
    expect_item("unwritten_pr9", K_RDA, 2, 32'h0);

    step(); wr(0, 9, 32'h11); wr(2, 9, 32'h22); rd(0, 9, 5);
    expect_item("coll_bypass", K_RDA, 0, 32'h22);
    expect_item("coll_not_yet", K_COL, 0, 32'h0);

    step(); rd(1, 9, 9);
    expect_item("coll_stored", K_RDA, 1, 32'h22);
    expect_item("coll_set", K_COL, 0, 32'h1);

    step(); alloc(0, 7); chk(1, 7);
    expect_item("alloc_invisible", K_CHK, 1, 32'h1);

    step(); chk(1, 7);
    expect_item("alloc_notready", K_CHK, 1, 32'h0);
    expect_item("coll_sticky", K_COL, 0, 32'h1);

    step(); wr(1, 7, 32'h77); chk(1, 7); rd(0, 7, 7);
    expect_item("cdb_bypass_rdy", K_CHK, 1, 32'h1);
    expect_item("cdb_bypass_data", K_RDA, 0, 32'h77);

    step(); chk(1, 7);
    expect_item("cdb_rdy_reg", K_CHK, 1, 32'h1);

    step(); alloc(2, 12); wr(1, 12, 32'hC); chk(3, 12);
    expect_item("alloc_wr_bypass", K_CHK, 3, 32'h1);

    step(); chk(3, 12); rd(0, 12, 9);
    expect_item("alloc_beats_wr", K_CHK, 3, 32'h0);
    expect_item("alloc_wr_data", K_RDA, 0, 32'hC);
    expect_item("pr9_keep", K_RDB, 0, 32'h22);

    step(); recover_en = 1'b1; recover_mask = 64'h1000;
    alloc(0, 12); wr(0, 20, 32'h20); chk(0, 12); chk(1, 20);
    expect_item("recover_invisible", K_CHK, 0, 32'h0);
    expect_item("recover_wr_bypass", K_CHK, 1, 32'h1);

    step(); chk(0, 12); chk(1, 0); chk(2, 5); chk(3, 20); chk(4, 63); chk(5, 9); rd(1, 20, 12);
    expect_item("rec_pr12", K_CHK, 0, 32'h1);
    expect_item("rec_zero", K_CHK, 1, 32'h1);
    expect_item("rec_pr5",  K_CHK, 2, 32'h0);
    expect_item("rec_pr20", K_CHK, 3, 32'h0);
    expect_item("rec_pr63", K_CHK, 4, 32'h0);
    expect_item("rec_pr9",  K_CHK, 5, 32'h0);
    expect_item("rec_data20", K_RDA, 1, 32'h20);
    expect_item("rec_data12", K_RDB, 1, 32'hC);

    step(); wr(2, 0, 32'hFFFF); rd(0, 0, 0); chk(4, 0);
    expect_item("zero_bypass", K_RDA, 0, 32'h0);
    expect_item("zero_rdy", K_CHK, 4, 32'h1);

    step(); rd(0, 0, 5);
    expect_item("zero_stored", K_RDA, 0, 32'h0);
    expect_item("pr5_after_zero", K_RDB, 0, 32'hDEAD);

    step(); wr(0, 30, 32'hAAAA); rd(0, 30, 30); chk(5, 5); chk(4, 20);
    #1 reset = 1'b0;
    expect_item("midrst_rda", K_RAWA, 0, 32'h0);
    expect_item("midrst_rdb", K_RAWB, 0, 32'h0);
    expect_item("midrst_vld", K_VLD, 0, 32'h0);
    expect_item("midrst_col", K_COL, 0, 32'h0);
    expect_item("midrst_chk5", K_CHK, 5, 32'h1);
    expect_item("midrst_chk20", K_CHK, 4, 32'h1);

    step(); reset = 1'b1; rd(0, 5, 9); chk(1, 7);
    expect_item("post_rst_pr5", K_RDA, 0, 32'h0);
    expect_item("post_rst_pr9", K_RDB, 0, 32'h0);
    expect_item("post_rst_col", K_COL, 0, 32'h0);
    expect_item("post_rst_chk7", K_CHK, 1, 32'h1);

    step();
    step();
    @(negedge clock);
    #1;
    n_total++;
    if (wr_collision === 1'b0) n_pass++;
    else $display("FAIL final_col actual=%b required=0", wr_collision);
    n_total++;
    if (chk_rdy === 6'b111111) n_pass++;
    else $display("FAIL final_chk actual=%b required=111111", chk_rdy);
    n_total++;
    if (rd_out_valid === 3'b000) n_pass++;
    else $display("FAIL final_vld actual=%b required=000", rd_out_valid);
    n_total++;
    if (rda_out[XLEN-1:0] === 32'h0) n_pass++;
    else $display("FAIL final_rda0 actual=%h required=0", rda_out[XLEN-1:0]);
    while (sbq.size() > 0) begin
      n_total++;
      $display("FAIL %s never compared actual=none required=%h", sbq[0].name, sbq[0].exp);
      void'(sbq.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
